// File: rtl/npu_add_tree_seq.sv
// Sequencer for the 8-lane NPU add tree: streams operand chunks from SRAM into the
// tree, tracks each chunk through the memory+tree pipeline and accumulates the results.
module npu_add_tree_seq #(
  parameter int LANES    = 8,
  parameter int AW       = 10,
  parameter int LENW     = 10,
  parameter int DWOUT    = 19,
  parameter int ACCW     = 32,
  parameter int MEM_LAT  = 1,
  parameter int TREE_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AW-1:0]        cfg_base,
  input  logic [LENW-1:0]      cfg_len,
  input  logic                 cfg_signed,
  output logic                 busy,
  output logic                 rd_en,
  output logic [AW-1:0]        rd_addr,
  input  logic [LANES*8-1:0]   rd_data,
  input  logic [LANES*8-1:0]   rd_para,
  output logic [LANES*8-1:0]   tree_data,
  output logic [LANES*8-1:0]   tree_para,
  output logic                 tree_signed,
  input  logic [DWOUT-1:0]     tree_result,
  output logic [ACCW-1:0]      acc_out,
  output logic                 acc_valid,
  input  logic                 acc_ready
);

  localparam int DEPTH = MEM_LAT + TREE_LAT;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [LENW-1:0] LEN_ONE  = {{(LENW-1){1'b0}}, 1'b1};
  localparam logic [LENW-1:0] LEN_ZERO = {LENW{1'b0}};
  localparam logic [AW-1:0]   AW_ONE   = {{(AW-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic             busy_q, busy_d;
  logic             rd_en_q, rd_en_d;
  logic [AW-1:0]    rd_addr_q, rd_addr_d;
  logic [LENW-1:0]  len_q, len_d;
  logic [LENW-1:0]  issued_q, issued_d;
  logic [LENW-1:0]  retired_q, retired_d;
  logic [ACCW-1:0]  acc_q, acc_d;
  logic             acc_valid_q, acc_valid_d;
  logic             signed_q, signed_d;
  logic [DEPTH-1:0] tag_q, tag_d;
  logic             retire_s;

  function automatic logic [ACCW-1:0] ext(input logic [DWOUT-1:0] r, input logic s);
    if (s) begin
      ext = {{(ACCW-DWOUT){r[DWOUT-1]}}, r};
    end else begin
      ext = {{(ACCW-DWOUT){1'b0}}, r};
    end
  endfunction

  // Next-state: tag shift, accumulation on retiring tags, and the control FSM.
  always_comb begin
    state_d     = state_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    retired_d   = retired_q;
    acc_d       = acc_q;
    acc_valid_d = acc_valid_q;
    signed_d    = signed_q;

    // A tag leaving the pipe lines up with the tree result of its chunk.
    tag_d[0] = rd_en_q;
    for (int i = 1; i < DEPTH; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    retire_s = tag_q[DEPTH-1];

    if (retire_s) begin
      acc_d     = acc_q + ext(tree_result, signed_q);
      retired_d = retired_q + LEN_ONE;
    end else begin
      acc_d     = acc_q;
      retired_d = retired_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d     = cfg_len;
          signed_d  = cfg_signed;
          acc_d     = {ACCW{1'b0}};
          issued_d  = LEN_ZERO;
          retired_d = LEN_ZERO;
          if (cfg_len != LEN_ZERO) begin
            state_d   = S_ISSUE;
            rd_en_d   = 1'b1;
            rd_addr_d = cfg_base;
          end else begin
            state_d     = S_OUT;
            acc_valid_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        issued_d = issued_q + LEN_ONE;
        if (issued_q == len_q - LEN_ONE) begin
          state_d = S_DRAIN;
          rd_en_d = 1'b0;
        end else begin
          rd_addr_d = rd_addr_q + AW_ONE;
        end
      end
      S_DRAIN: begin
        if (retire_s && (retired_q == len_q - LEN_ONE)) begin
          state_d     = S_OUT;
          acc_valid_d = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_OUT: begin
        if (acc_ready) begin
          state_d     = S_IDLE;
          acc_valid_d = 1'b0;
        end else begin
          state_d = S_OUT;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rd_en_d     = 1'b0;
        acc_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State registers; reset also flushes in-flight tags so late tree results are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= {AW{1'b0}};
      len_q       <= LEN_ZERO;
      issued_q    <= LEN_ZERO;
      retired_q   <= LEN_ZERO;
      acc_q       <= {ACCW{1'b0}};
      acc_valid_q <= 1'b0;
      signed_q    <= 1'b0;
      tag_q       <= {DEPTH{1'b0}};
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      retired_q   <= retired_d;
      acc_q       <= acc_d;
      acc_valid_q <= acc_valid_d;
      signed_q    <= signed_d;
      tag_q       <= tag_d;
    end
  end

  assign busy        = busy_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign tree_data   = rd_data;
  assign tree_para   = rd_para;
  assign tree_signed = signed_q;
  assign acc_out     = acc_q;
  assign acc_valid   = acc_valid_q;

endmodule

// File: tb/tb_npu_add_tree_seq.sv
// Self-checking bench for npu_add_tree_seq: SRAM and add-tree models plus a
// plain-arithmetic dot-product reference.
module tb_npu_add_tree_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  cfg_base;
  logic [9:0]  cfg_len;
  logic        cfg_signed;
  logic        busy;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data = 64'd0;
  logic [63:0] rd_para = 64'd0;
  logic [63:0] tree_data;
  logic [63:0] tree_para;
  logic        tree_signed;
  logic [18:0] tree_result;
  logic [31:0] acc_out;
  logic        acc_valid;
  logic        acc_ready;

  logic [63:0] mem_d [0:1023];
  logic [63:0] mem_p [0:1023];
  logic [18:0] tp1 = 19'd0;
  logic [18:0] tp2 = 19'd0;
  logic        tree_force = 1'b0;
  logic [9:0]  addr_log [0:2047];
  int          rd_count = 0;

  int n_checks = 0;
  int n_fail   = 0;

  npu_add_tree_seq dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_signed(cfg_signed), .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_para(rd_para), .tree_data(tree_data), .tree_para(tree_para),
    .tree_signed(tree_signed), .tree_result(tree_result), .acc_out(acc_out),
    .acc_valid(acc_valid), .acc_ready(acc_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] tree_dot(input logic [63:0] d, input logic [63:0] p, input logic s);
    int sum = 0;
    logic [7:0] a, b;
    for (int l = 0; l < 8; l++) begin
      a = d[8*l +: 8];
      b = p[8*l +: 8];
      if (s) sum += int'($signed(a)) * int'($signed(b));
      else   sum += int'(a) * int'(b);
    end
    return sum[18:0];
  endfunction

  // Reference: exact dot product over the addressed chunks, reduced mod 2^32.
  function automatic logic [31:0] ref_acc(input logic [9:0] base, input int len, input logic s);
    longint sum = 0;
    logic [9:0] a;
    logic [7:0] x, y;
    for (int i = 0; i < len; i++) begin
      a = base + 10'(i);
      for (int l = 0; l < 8; l++) begin
        x = mem_d[a][8*l +: 8];
        y = mem_p[a][8*l +: 8];
        if (s) sum += longint'($signed(x)) * longint'($signed(y));
        else   sum += longint'(x) * longint'(y);
      end
    end
    return sum[31:0];
  endfunction

  // SRAM (1-cycle read) and add tree (2-cycle) models, plus a read-address log.
  always @(posedge clk) begin
    tp1 <= tree_dot(tree_data, tree_para, tree_signed);
    tp2 <= tp1;
    if (rd_en) begin
      rd_data  <= mem_d[rd_addr];
      rd_para  <= mem_p[rd_addr];
      addr_log[rd_count % 2048] <= rd_addr;
      rd_count <= rd_count + 1;
    end
  end

  assign tree_result = tree_force ? 19'h7FFF8 : tp2;

  task automatic run_op(input logic [9:0] base, input logic [9:0] len, input logic s,
                        output int lat, output bit to);
    @(negedge clk);
    start = 1'b1; cfg_base = base; cfg_len = len; cfg_signed = s;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!acc_valid && lat < 200) begin
      cfg_base = 10'($urandom); cfg_len = 10'($urandom); cfg_signed = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    to = !acc_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; acc_ready = 1'b0;
    cfg_base = 10'd0; cfg_len = 10'd0; cfg_signed = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, rd_en, acc_valid, tree_signed} !== 4'b0000 || acc_out !== 32'd0 || rd_addr !== 10'd0) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b rd_en=%b valid=%b sgn=%b acc=%h addr=%0d required all zero",
               busy, rd_en, acc_valid, tree_signed, acc_out, rd_addr);
    end
    @(negedge clk);
    start = 1'b1; cfg_base = 10'd100; cfg_len = 10'd8; cfg_signed = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (!(busy && rd_en)) begin
      n_fail++;
      $display("FAIL reset_mid_issue_active: got busy=%b rd_en=%b required 1 1", busy, rd_en);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, rd_en, acc_valid} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_abort: got busy=%b rd_en=%b valid=%b required 0 0 0", busy, rd_en, acc_valid);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (acc_out !== 32'd0 || acc_valid !== 1'b0 || rd_en !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_no_accumulate: cycle %0d got acc=%h valid=%b rd_en=%b required 0 0 0",
                 i, acc_out, acc_valid, rd_en);
      end
    end
  endtask

  task automatic test_len1();
    int lat; bit to;
    mem_d[5] = 64'h0101010101010101;
    mem_p[5] = 64'h0101010101010101;
    run_op(10'd5, 10'd1, 1'b1, lat, to);
    n_checks++;
    if (to || lat != 5) begin
      n_fail++;
      $display("FAIL len1_latency: got %0d cycles (timeout=%b) required 5", lat, to);
    end
    n_checks++;
    if (acc_out !== 32'd8) begin
      n_fail++;
      $display("FAIL len1_acc: got %h required %h", acc_out, 32'd8);
    end
    acc_ready = 1'b1; @(negedge clk); acc_ready = 1'b0;
    n_checks++;
    if (acc_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len1_accept: got valid=%b busy=%b required 0 0", acc_valid, busy);
    end
  endtask

  task automatic test_ext();
    int lat; bit to;
    logic [31:0] exp_v [2];
    exp_v[0] = 32'h001FFFE0;
    exp_v[1] = 32'hFFFFFFE0;
    tree_force = 1'b1;
    for (int s = 1; s >= 0; s--) begin
      run_op(10'd200, 10'd4, 1'(s), lat, to);
      n_checks++;
      if (to || lat != 8) begin
        n_fail++;
        $display("FAIL ext_latency s=%0d: got %0d cycles required 8", s, lat);
      end
      n_checks++;
      if (acc_out !== exp_v[s]) begin
        n_fail++;
        $display("FAIL ext_acc s=%0d: got %h required %h", s, acc_out, exp_v[s]);
      end
      acc_ready = 1'b1; @(negedge clk); acc_ready = 1'b0;
    end
    tree_force = 1'b0;
  endtask

  task automatic test_len0();
    int lat; bit to; int rc0;
    rc0 = rd_count;
    run_op(10'd7, 10'd0, 1'b0, lat, to);
    n_checks++;
    if (to || lat != 1 || acc_out !== 32'd0) begin
      n_fail++;
      $display("FAIL len0: got lat=%0d acc=%h required lat=1 acc=0", lat, acc_out);
    end
    acc_ready = 1'b1; @(negedge clk); acc_ready = 1'b0;
    n_checks++;
    if (rd_count != rc0) begin
      n_fail++;
      $display("FAIL len0_no_read: got %0d reads required 0", rd_count - rc0);
    end
  endtask

  task automatic test_backpressure();
    int lat; bit to; int rc0;
    logic [31:0] e;
    e = ref_acc(10'd300, 3, 1'b1);
    run_op(10'd300, 10'd3, 1'b1, lat, to);
    rc0 = rd_count;
    for (int i = 0; i < 10; i++) begin
      start = (i == 2 || i == 5); cfg_len = 10'd0; cfg_base = 10'd9;
      @(negedge clk);
      n_checks++;
      if (acc_valid !== 1'b1 || acc_out !== e) begin
        n_fail++;
        $display("FAIL backpressure_hold: cycle %0d got valid=%b acc=%h required 1 %h", i, acc_valid, acc_out, e);
      end
    end
    start = 1'b0;
    n_checks++;
    if (rd_count != rc0) begin
      n_fail++;
      $display("FAIL backpressure_start_ignored: got %0d reads required 0", rd_count - rc0);
    end
    start = 1'b1; acc_ready = 1'b1; cfg_len = 10'd0;
    @(negedge clk);
    start = 1'b0; acc_ready = 1'b0;
    n_checks++;
    if (acc_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL out_exit_start_ignored: got valid=%b busy=%b required 0 0", acc_valid, busy);
    end
  endtask

  task automatic test_wrap();
    int lat; bit to; int rc0;
    logic [9:0] exp_a [4];
    logic [31:0] e;
    exp_a[0] = 10'd1022; exp_a[1] = 10'd1023; exp_a[2] = 10'd0; exp_a[3] = 10'd1;
    rc0 = rd_count;
    e = ref_acc(10'd1022, 4, 1'b0);
    run_op(10'd1022, 10'd4, 1'b0, lat, to);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (addr_log[(rc0 + i) % 2048] !== exp_a[i]) begin
        n_fail++;
        $display("FAIL wrap_addr[%0d]: got %0d required %0d", i, addr_log[(rc0 + i) % 2048], exp_a[i]);
      end
    end
    n_checks++;
    if (to || acc_out !== e) begin
      n_fail++;
      $display("FAIL wrap_acc: got %h required %h", acc_out, e);
    end
    acc_ready = 1'b1; @(negedge clk); acc_ready = 1'b0;
    run_op(10'd50, 10'd0, 1'b0, lat, to);
    n_checks++;
    if (to || acc_out !== 32'd0) begin
      n_fail++;
      $display("FAIL restart_clears_acc: got %h required 0", acc_out);
    end
    acc_ready = 1'b1; @(negedge clk); acc_ready = 1'b0;
  endtask

  task automatic test_random();
    int lat; bit to; int len;
    logic [9:0] base; logic s;
    logic [31:0] e;
    for (int k = 0; k < 8; k++) begin
      len  = $urandom_range(1, 20);
      base = 10'($urandom);
      s    = 1'($urandom);
      e    = ref_acc(base, len, s);
      run_op(base, 10'(len), s, lat, to);
      n_checks++;
      if (to || lat != len + 4 || acc_out !== e) begin
        n_fail++;
        $display("FAIL random_op%0d: got lat=%0d acc=%h required lat=%0d acc=%h", k, lat, acc_out, len + 4, e);
      end
      acc_ready = 1'b1; @(negedge clk); acc_ready = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_d[i] = {$urandom, $urandom};
      mem_p[i] = {$urandom, $urandom};
    end
    test_reset();
    test_len1();
    test_ext();
    test_len0();
    test_backpressure();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
